// File: rtl/instr_sequencer_if.sv
// Memory-bus handshake between instr_sequencer (master) and the single-port memory (slave).
interface instr_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_ifetch;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_ifetch, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_ifetch, output mem_ready);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the WRAMP core.
// Define SEQ_TRAP_EN to build the TRAP state (illegal opcodes and bus timeouts vector to a trap).
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_sequencer_if.master        bus,
    input  logic [3:0]               op_code,
    input  logic                     lw,
    input  logic                     sw,
    input  logic                     jump,
    input  logic                     jal,
    input  logic                     jr,
    input  logic                     beqz,
    input  logic                     bnez,
    input  logic                     reg_write,
    input  logic                     src_zero,
    output logic                     ir_load,
    output logic                     pc_load,
    output logic [1:0]               pc_sel,
    output logic                     rf_write,
    output logic [1:0]               rf_wsel,
    output logic                     bus_err,
    output logic                     trap,
    output logic [2:0]               state,
    output logic [CNT_W-1:0]         retired
);
    localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_MEM, C_JAL, C_JR, C_JUMP, C_BEQZ, C_BNEZ
    } cls_e;

    localparam logic [1:0] PC_INC = 2'd0, PC_IMM = 2'd1, PC_REG = 2'd2, PC_VEC = 2'd3;
    localparam logic [1:0] WS_ALU = 2'd0, WS_MEM = 2'd1, WS_LINK = 2'd2;

`ifdef SEQ_TRAP_EN
    localparam state_e ERR_NEXT = S_TRAP;
`else
    localparam state_e ERR_NEXT = S_FETCH;
`endif

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal, bus_state, timeout, retire;
    cls_e              cls;

    // Register writes are implied by the operation class, so the decoded flag is not needed.
    logic unused_decode;
    assign unused_decode = reg_write;

    assign illegal   = (op_code == 4'b0010) || (op_code == 4'b0111) || (op_code[3:2] == 2'b11);
    assign bus_state = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = bus_state && !bus.mem_ready && (to_cnt_q == TO_W'(MEM_TIMEOUT));

    always_comb begin
        if (illegal)                                                   cls = C_NOP;
        else if (op_code == 4'b0000 || op_code == 4'b0001 || op_code == 4'b0011) cls = C_ALU;
        else if (lw || sw)                                             cls = C_MEM;
        else if (jal)                                                  cls = C_JAL;
        else if (jr)                                                   cls = C_JR;
        else if (jump)                                                 cls = C_JUMP;
        else if (beqz)                                                 cls = C_BEQZ;
        else if (bnez)                                                 cls = C_BNEZ;
        else                                                           cls = C_NOP;
    end

    // NOTE: sequential state is updated with non-blocking assignments only; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            to_cnt_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = (bus_state && !bus.mem_ready && !timeout) ? to_cnt_q + TO_W'(1) : '0;
        retired_d = retired_q + CNT_W'(retire);
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
                      else if (timeout)  state_d = ERR_NEXT;
            S_DECODE: begin
                state_d = S_EXEC;
`ifdef SEQ_TRAP_EN
                if (illegal) state_d = S_TRAP;
`endif
            end
            S_EXEC:   if (cls == C_ALU)      state_d = S_WB;
                      else if (cls == C_MEM) state_d = S_MEM;
                      else                   state_d = S_FETCH;
            S_MEM:    if (bus.mem_ready) state_d = lw ? S_WB : S_FETCH;
                      else if (timeout)  state_d = ERR_NEXT;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_ifetch = 1'b0;
        ir_load        = 1'b0;
        pc_load        = 1'b0;
        pc_sel         = PC_INC;
        rf_write       = 1'b0;
        rf_wsel        = WS_ALU;
        bus_err        = 1'b0;
        trap           = 1'b0;
        retire         = 1'b0;
        if (!rst) begin
            bus_err = timeout;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.mem_ifetch = 1'b1;
                    ir_load        = bus.mem_ready;
`ifndef SEQ_TRAP_EN
                    pc_load        = timeout;
`endif
                end
                S_EXEC: begin
                    pc_load = (cls != C_ALU) && (cls != C_MEM);
                    retire  = pc_load;
                    case (cls)
                        C_JAL:   begin pc_sel = PC_IMM; rf_write = 1'b1; rf_wsel = WS_LINK; end
                        C_JR:    pc_sel = PC_REG;
                        C_JUMP:  pc_sel = PC_IMM;
                        C_BEQZ:  pc_sel = src_zero ? PC_IMM : PC_INC;
                        C_BNEZ:  pc_sel = src_zero ? PC_INC : PC_IMM;
                        default: pc_sel = PC_INC;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = sw;
                    if (bus.mem_ready && !lw) begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                    end
`ifndef SEQ_TRAP_EN
                    else if (timeout) pc_load = 1'b1;
`endif
                end
                S_WB: begin
                    rf_write = 1'b1;
                    rf_wsel  = lw ? WS_MEM : WS_ALU;
                    pc_load  = 1'b1;
                    retire   = 1'b1;
                end
`ifdef SEQ_TRAP_EN
                S_TRAP: begin
                    trap    = 1'b1;
                    pc_load = 1'b1;
                    pc_sel  = PC_VEC;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level reference model pushes per-cycle expectations
// into a scoreboard queue while driving the bus; a negedge monitor pops and compares them.
module tb_instr_sequencer;
    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5;

    typedef enum int {K_ALU, K_LW, K_SW, K_J, K_JAL, K_JR, K_BEQZ, K_BNEZ, K_ILL} kind_e;

    typedef struct packed {
        logic          care;
        logic          mem_req, mem_we, mem_ifetch, ir_load, pc_load;
        logic [1:0]    pc_sel;
        logic          rf_write;
        logic [1:0]    rf_wsel;
        logic          bus_err, trap;
        logic [2:0]    state;
        logic [CW-1:0] retired;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    op_code = '0;
    logic          lw = 0, sw = 0, jump = 0, jal = 0, jr = 0, beqz = 0, bnez = 0;
    logic          reg_write = 0, src_zero = 0;
    logic          ir_load, pc_load, rf_write, bus_err, trap;
    logic [1:0]    pc_sel, rf_wsel;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    instr_sequencer_if bus();

    instr_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .op_code(op_code),
        .lw(lw), .sw(sw), .jump(jump), .jal(jal), .jr(jr), .beqz(beqz), .bnez(bnez),
        .reg_write(reg_write), .src_zero(src_zero),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .rf_write(rf_write),
        .rf_wsel(rf_wsel), .bus_err(bus_err), .trap(trap), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   model_retired = 0;
    exp_t mon_e, mon_a, mon_m;

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {1'b1, bus.mem_req, bus.mem_we, bus.mem_ifetch, ir_load, pc_load, pc_sel,
                     rf_write, rf_wsel, bus_err, trap, state, retired};
            mon_m = '1;
            mon_m.care = 1'b0;
            if (!mon_e.care) begin mon_m.state = '0; mon_m.retired = '0; end
            if (!mon_e.mem_req || mon_e.mem_ifetch) mon_m.mem_we = 1'b0;
            if (!mon_e.pc_load)  mon_m.pc_sel  = '0;
            if (!mon_e.rf_write) mon_m.rf_wsel = '0;
            checks++;
            if (((mon_a ^ mon_e) & mon_m) != '0) begin
                errors++;
                $display("FAIL cycle_%0d: got req/we/if/ir/pl/sel/rw/ws/be/tr/st/ret=%b required=%b care=%b",
                         cyc, mon_a, mon_e, mon_m);
            end
            cyc++;
        end
    end

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e = '0;
        e.care  = 1'b1;
        e.state = st;
        return e;
    endfunction

    task automatic step(input exp_t e_in);
        exp_t e = e_in;
        e.retired = CW'(model_retired);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input exp_t e);
        bus.mem_ready = 1'($urandom);
        step(e);
    endtask

    task automatic rand_decode();
        op_code = 4'($urandom);
        {lw, sw, jump, jal, jr, beqz, bnez, reg_write, src_zero} = 9'($urandom);
    endtask

    task automatic set_decode(input kind_e k, input logic [3:0] op, input logic sz);
        op_code = op;
        {lw, sw, jump, jal, jr, beqz, bnez, reg_write} = '0;
        src_zero = sz;
        case (k)
            K_ALU:  reg_write = 1'b1;
            K_LW:   begin lw = 1'b1; reg_write = 1'b1; end
            K_SW:   sw = 1'b1;
            K_J:    jump = 1'b1;
            K_JAL:  begin jal = 1'b1; reg_write = 1'b1; end
            K_JR:   jr = 1'b1;
            K_BEQZ: beqz = 1'b1;
            K_BNEZ: bnez = 1'b1;
            default: ;
        endcase
    endtask

    task automatic trap_step();
        exp_t e = mk(S_TRAP);
        e.trap = 1'b1; e.pc_load = 1'b1; e.pc_sel = 2'd3;
        idle_step(e);
    endtask

    // Bus phase: 'waits' cycles with mem_ready low, then ready; more than TIMEOUT waits is a bus error.
    task automatic bus_phase(input bit fetch, input bit we, input int waits, output bit ok);
        exp_t e;
        bit   done = 0;
        ok = 0;
        for (int c = 0; !done; c++) begin
            if (fetch) rand_decode();
            e = mk(fetch ? S_FETCH : S_MEM);
            e.mem_req = 1'b1; e.mem_ifetch = fetch; e.mem_we = we;
            if (c < waits) begin
                bus.mem_ready = 1'b0;
                if (c == TIMEOUT) begin
                    e.bus_err = 1'b1;
`ifndef SEQ_TRAP_EN
                    e.pc_load = 1'b1; e.pc_sel = 2'd0;
`endif
                    step(e);
`ifdef SEQ_TRAP_EN
                    trap_step();
`endif
                    done = 1;
                end else begin
                    step(e);
                end
            end else begin
                bus.mem_ready = 1'b1;
                if (fetch) e.ir_load = 1'b1;
                else if (we) begin e.pc_load = 1'b1; e.pc_sel = 2'd0; end
                step(e);
                if (!fetch && we) model_retired++;
                ok = 1; done = 1;
            end
        end
    endtask

    task automatic wb_step(input bit is_lw);
        exp_t e = mk(S_WB);
        e.rf_write = 1'b1; e.rf_wsel = is_lw ? 2'd1 : 2'd0;
        e.pc_load  = 1'b1; e.pc_sel  = 2'd0;
        idle_step(e);
        model_retired++;
    endtask

    task automatic run_instr(input kind_e k, input logic [3:0] op, input logic sz,
                             input int fw, input int mw);
        exp_t e;
        bit   ok;
        bus_phase(1'b1, 1'b0, fw, ok);
        if (ok) begin
            set_decode(k, op, sz);
            idle_step(mk(S_DECODE));
`ifdef SEQ_TRAP_EN
            if (k == K_ILL) begin
                trap_step();
                return;
            end
`endif
            e = mk(S_EXEC);
            case (k)
                K_J:    begin e.pc_load = 1'b1; e.pc_sel = 2'd1; end
                K_JR:   begin e.pc_load = 1'b1; e.pc_sel = 2'd2; end
                K_JAL:  begin e.pc_load = 1'b1; e.pc_sel = 2'd1; e.rf_write = 1'b1; e.rf_wsel = 2'd2; end
                K_BEQZ: begin e.pc_load = 1'b1; e.pc_sel = sz ? 2'd1 : 2'd0; end
                K_BNEZ: begin e.pc_load = 1'b1; e.pc_sel = sz ? 2'd0 : 2'd1; end
                K_ILL:  begin e.pc_load = 1'b1; e.pc_sel = 2'd0; end
                default: ;
            endcase
            idle_step(e);
            if (k == K_ALU) wb_step(1'b0);
            else if (k == K_LW || k == K_SW) begin
                bus_phase(1'b0, k == K_SW, mw, ok);
                if (ok && k == K_LW) wb_step(1'b1);
            end else model_retired++;
        end
    endtask

    task automatic reset_in_mem();
        bit ok;
        bus_phase(1'b1, 1'b0, 0, ok);
        set_decode(K_SW, 4'b1001, 1'b0);
        idle_step(mk(S_DECODE));
        idle_step(mk(S_EXEC));
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        step('0);
        rst = 1'b0;
        model_retired = 0;
    endtask

    function automatic logic [3:0] pick_op(input kind_e k);
        logic [3:0] alu_ops [3] = '{4'b0000, 4'b0001, 4'b0011};
        logic [3:0] ill_ops [6] = '{4'b0010, 4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        case (k)
            K_ALU:  return alu_ops[$urandom_range(0, 2)];
            K_J:    return 4'b0100;
            K_JAL:  return 4'b0101;
            K_JR:   return 4'b0110;
            K_LW:   return 4'b1000;
            K_SW:   return 4'b1001;
            K_BEQZ: return 4'b1010;
            K_BNEZ: return 4'b1011;
            default: return ill_ops[$urandom_range(0, 5)];
        endcase
    endfunction

    function automatic int rand_wait();
        int r = $urandom_range(0, 9);
        if (r < 5) return 0;
        if (r < 9) return r - 4;
        return TIMEOUT + 1 + $urandom_range(0, 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kind_e k;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rand_decode();
        step(mk(S_FETCH));
        rand_decode();
        step(mk(S_FETCH));
        rst = 1'b0;

        run_instr(K_ALU,  4'b0000, 1'b0, 0, 0);
        run_instr(K_LW,   4'b1000, 1'b0, 0, 3);
        run_instr(K_BEQZ, 4'b1010, 1'b1, 0, 0);
        run_instr(K_BNEZ, 4'b1011, 1'b1, 0, 0);
        run_instr(K_ALU,  4'b0001, 1'b0, TIMEOUT + 3, 0);
        run_instr(K_J,    4'b0100, 1'b0, TIMEOUT, 0);
        run_instr(K_ILL,  4'b1100, 1'b0, 0, 0);
        run_instr(K_SW,   4'b1001, 1'b0, 1, TIMEOUT + 1);
        run_instr(K_SW,   4'b1001, 1'b0, 0, TIMEOUT);
        reset_in_mem();
        for (int i = 0; i < (1 << CW); i++) run_instr(K_J, 4'b0100, 1'b0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            k = kind_e'($urandom_range(0, 8));
            run_instr(k, pick_op(k), 1'($urandom), rand_wait(), rand_wait());
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
